// File: rtl/inst_fetch.sv
// inst_fetch: PC register, in-order imem word reads, FETCH_DEPTH-entry FIFO to decode.
// Optional FETCH_ADEL_CHK_EN: adds out_adel and turns misaligned fetches into marker entries.
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
`ifdef FETCH_ADEL_CHK_EN
    output logic        out_adel,
`endif
    output logic [31:0] out_pc
);
    localparam int AW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FETCH_DEPTH);
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [31:0]   r_pc;
    logic [0:0]    r_state;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_tag_wptr;
    logic [AW-1:0] r_tag_rptr;
    logic [31:0]   r_fifo_inst [FETCH_DEPTH];
    logic [31:0]   r_fifo_pc   [FETCH_DEPTH];
    logic [31:0]   r_tag_pc    [FETCH_DEPTH];

    logic          w_credit;
    logic          w_issue;
    logic          w_halt;
    logic          w_gnt;
    logic          w_accept;
    logic          w_owed;
    logic          w_push;
    logic          w_pop;
    logic          w_adel_push;
    logic [31:0]   w_redir_pc;
    logic [31:0]   w_reset_pc;
    logic [31:0]   w_push_pc;
    logic [31:0]   w_push_inst;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_outst_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Responses in flight plus buffered words may never exceed the FIFO size.
    assign w_credit = ({1'b0, r_outst} + {1'b0, r_cnt}) < DEPTH_W;
    assign w_issue  = resetn & !redirect_valid & w_credit
                    & (r_state == S_RUN) & !w_halt;

`ifdef FETCH_ADEL_CHK_EN
    logic r_halt;
    logic r_fifo_adel [FETCH_DEPTH];
    logic w_mis;

    assign w_mis       = r_pc[1:0] != 2'b00;
    assign w_halt      = r_halt;
    assign imem_req    = w_issue & !w_mis;
    // Marker waits for in-flight words so it lands behind them in order.
    assign w_adel_push = w_issue & w_mis & (r_outst == '0);
    assign w_redir_pc  = redirect_pc;
    assign w_reset_pc  = RESET_PC;
    assign out_adel    = out_valid & r_fifo_adel[r_rptr];

    // Fetch stops after a misaligned marker until software redirects.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_halt <= 1'b0;
        end else if (redirect_valid) begin
            r_halt <= 1'b0;
        end else if (w_adel_push) begin
            r_halt <= 1'b1;
        end
    end

    // Marker flag storage alongside each FIFO entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_adel[r_wptr] <= w_adel_push;
        end
    end
`else
    assign w_halt      = 1'b0;
    assign imem_req    = w_issue;
    assign w_adel_push = 1'b0;
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_reset_pc  = RESET_PC & 32'hFFFF_FFFC;
`endif

    assign imem_addr = r_pc;
    assign w_gnt     = imem_req & imem_gnt;
    assign w_accept  = imem_rvalid & (r_drop == '0) & (r_outst != '0);
    assign w_owed    = imem_rvalid & ((r_drop != '0) | (r_outst != '0));
    assign w_push    = (w_accept & !redirect_valid) | w_adel_push;
    assign w_pop     = out_valid & out_ready & !redirect_valid;

    assign w_push_pc   = w_adel_push ? r_pc : r_tag_pc[r_tag_rptr];
    assign w_push_inst = w_adel_push ? 32'h0 : imem_rdata;

    assign out_valid = r_cnt != '0;
    assign out_inst  = out_valid ? r_fifo_inst[r_rptr] : 32'h0;
    assign out_pc    = out_valid ? r_fifo_pc[r_rptr] : 32'h0;

    // Next counts: a redirect turns owed responses into ones to discard.
    always_comb begin
        w_drop_nxt  = r_drop;
        w_outst_nxt = r_outst;
        w_cnt_nxt   = r_cnt;
        if (redirect_valid) begin
            w_drop_nxt  = r_drop + r_outst - CW'(w_owed);
            w_outst_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            if (imem_rvalid && (r_drop != '0)) begin
                w_drop_nxt = r_drop - CW'(1);
            end
            unique case ({w_gnt, w_accept})
                2'b10:   w_outst_nxt = r_outst + CW'(1);
                2'b01:   w_outst_nxt = r_outst - CW'(1);
                default: w_outst_nxt = r_outst;
            endcase
            unique case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + CW'(1);
                2'b01:   w_cnt_nxt = r_cnt - CW'(1);
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    // PC, counters and RUN/DRAIN state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc    <= w_reset_pc;
            r_state <= S_RUN;
            r_outst <= '0;
            r_drop  <= '0;
            r_cnt   <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_redir_pc;
            end else if (w_gnt) begin
                r_pc <= r_pc + 32'd4;
            end
            r_state <= (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
            r_outst <= w_outst_nxt;
            r_drop  <= w_drop_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FIFO and tag-queue pointers; a redirect empties both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
        end else if (redirect_valid) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_gnt) r_tag_wptr <= r_tag_wptr + AW'(1);
            if (w_accept) r_tag_rptr <= r_tag_rptr + AW'(1);
        end
    end

    // Entry storage; contents only matter behind valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wptr] <= w_push_inst;
            r_fifo_pc[r_wptr]   <= w_push_pc;
        end
        if (w_gnt) begin
            r_tag_pc[r_tag_wptr] <= r_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a one-cycle-latency memory.
// Define FETCH_ADEL_CHK_EN for both files to exercise the misaligned-fetch marker.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef FETCH_ADEL_CHK_EN
    logic        out_adel;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          n_gnt = 0;
    bit          mon_en = 1'b1;
    bit          resp_en = 1'b0;
    logic [31:0] expq[$];
    logic [31:0] inflight[$];

    inst_fetch dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
`ifdef FETCH_ADEL_CHK_EN
        .out_adel       (out_adel),
`endif
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) expq.push_back(base + 32'(4 * i));
    endtask

    // Check pops, record grants, advance one clock, drive memory response.
    task automatic cyc();
        logic [31:0] e;
        if (mon_en && out_valid && out_ready && !redirect_valid) begin
            n_pop++;
            if (expq.size() == 0) begin
                chk("extra_pop", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_inst", out_inst, memf(e));
`ifdef FETCH_ADEL_CHK_EN
                chk("out_adel", 32'(out_adel), 32'h0);
`endif
            end
        end
        if (imem_req && imem_gnt) begin
            inflight.push_back(imem_addr);
            n_gnt++;
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        if (resp_en && inflight.size() != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(inflight.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic wait_req(input int max);
        int k = 0;
        while (!imem_req && k < max) begin
            cyc();
            k++;
        end
        chk("req_resume", 32'(imem_req), 32'h1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        chk("redir_noreq", 32'(imem_req), 32'h0);
        cyc();
        expq.delete();
    endtask

    task automatic enter_reset();
        resetn      = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inflight.delete();
        expq.delete();
        #1;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_oval", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // Streaming from reset
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        resp_en   = 1'b1;
        leave_reset();
        fill(32'hBFC0_0000, 16);
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr0", imem_addr, 32'hBFC0_0000);
        chk("t1_nobyp0", 32'(out_valid), 32'h0);
        cyc();
        chk("t1_addr1", imem_addr, 32'hBFC0_0004);
        chk("t1_nobyp1", 32'(out_valid), 32'h0);
        cyc();
        chk("t1_oval", 32'(out_valid), 32'h1);
        chk("t1_opc", out_pc, 32'hBFC0_0000);
        n_pop = 0;
        repeat (12) cyc();
        chk("t1_pops", 32'(n_pop), 32'd8);

        // Back-pressure: credits stop requests at FETCH_DEPTH
        out_ready = 1'b0;
        redirect(32'h0000_1000);
        chk("t2_flush", 32'(out_valid), 32'h0);
        wait_req(8);
        chk("t2_addr", imem_addr, 32'h0000_1000);
        n_gnt = 0;
        repeat (6) cyc();
        chk("t2_gnts", 32'(n_gnt), 32'd2);
        chk("t2_req0", 32'(imem_req), 32'h0);
        chk("t2_hold_pc", out_pc, 32'h0000_1000);
        chk("t2_hold_inst", out_inst, memf(32'h0000_1000));
        repeat (3) cyc();
        chk("t2_hold_pc2", out_pc, 32'h0000_1000);
        fill(32'h0000_1000, 16);
        out_ready = 1'b1;
        #1;
        n_pop = 0;
        repeat (9) cyc();
        chk("t2_pops", 32'(n_pop), 32'd6);

        // Reset mid-stream, then redirect with two responses owed
        resp_en = 1'b0;
        enter_reset();
        chk("t5_req", 32'(imem_req), 32'h0);
        chk("t5_oval", 32'(out_valid), 32'h0);
        chk("t5_inst", out_inst, 32'h0);
        chk("t5_pc", out_pc, 32'h0);
        leave_reset();
        chk("t5_addr", imem_addr, 32'hBFC0_0000);
        chk("t5_req1", 32'(imem_req), 32'h1);
        cyc();
        chk("t3_addr1", imem_addr, 32'hBFC0_0004);
        cyc();
        chk("t3_credit", 32'(imem_req), 32'h0);
        redirect(32'h8000_0180);
        fill(32'h8000_0180, 8);
        chk("t3_drain0", 32'(imem_req), 32'h0);
        chk("t3_oval0", 32'(out_valid), 32'h0);
        resp_en = 1'b1;
        cyc();
        chk("t3_drain1", 32'(imem_req), 32'h0);
        cyc();
        chk("t3_drain2", 32'(imem_req), 32'h0);
        chk("t3_oval2", 32'(out_valid), 32'h0);
        cyc();
        chk("t3_resume", 32'(imem_req), 32'h1);
        chk("t3_addr", imem_addr, 32'h8000_0180);
        cyc();
        cyc();
        chk("t3_oval", 32'(out_valid), 32'h1);
        chk("t3_opc", out_pc, 32'h8000_0180);
        repeat (4) cyc();

        // Redirect coinciding with rvalid and pop
        enter_reset();
        leave_reset();
        cyc();
        cyc();
        chk("t4_setup_ov", 32'(out_valid), 32'h1);
        chk("t4_setup_rv", 32'(imem_rvalid), 32'h1);
        redirect(32'h8000_0200);
        fill(32'h8000_0200, 8);
        chk("t4_flush", 32'(out_valid), 32'h0);
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h8000_0200);
        cyc();
        chk("t4_oval1", 32'(out_valid), 32'h0);
        cyc();
        chk("t4_oval2", 32'(out_valid), 32'h1);
        chk("t4_opc", out_pc, 32'h8000_0200);
        repeat (4) cyc();

        // PC wraps past the top of the address space
        redirect(32'hFFFF_FFFC);
        expq.push_back(32'hFFFF_FFFC);
        fill(32'h0000_0000, 8);
        wait_req(8);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        n_pop = 0;
        repeat (10) cyc();
        chk("wrap_pops", 32'(n_pop), 32'd6);

`ifdef FETCH_ADEL_CHK_EN
        // Misaligned target becomes a single marker entry
        mon_en    = 1'b0;
        out_ready = 1'b0;
        n_gnt     = 0;
        redirect(32'h8000_0002);
        for (int k = 0; k < 10 && !out_valid; k++) cyc();
        chk("t6_oval", 32'(out_valid), 32'h1);
        chk("t6_pc", out_pc, 32'h8000_0002);
        chk("t6_inst", out_inst, 32'h0);
        chk("t6_adel", 32'(out_adel), 32'h1);
        chk("t6_req", 32'(imem_req), 32'h0);
        out_ready = 1'b1;
        #1;
        cyc();
        chk("t6_popped", 32'(out_valid), 32'h0);
        repeat (4) cyc();
        chk("t6_idle_req", 32'(imem_req), 32'h0);
        chk("t6_idle_ov", 32'(out_valid), 32'h0);
        chk("t6_nogrant", 32'(n_gnt), 32'd0);
        mon_en = 1'b1;
        redirect(32'h8000_0000);
        fill(32'h8000_0000, 8);
        wait_req(4);
        chk("t6_addr", imem_addr, 32'h8000_0000);
        repeat (6) cyc();
`else
        // Without the check, low PC bits are dropped on load
        redirect(32'h8000_0002);
        fill(32'h8000_0000, 8);
        wait_req(8);
        chk("t6_align", imem_addr, 32'h8000_0000);
        repeat (6) cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
